// File: rtl/mdu_pkg.sv
// Shared types and helpers for the M-extension divide path.
package mdu_pkg;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        FLUSH     = 3'd0,
        RELEASE_F = 3'd1,
        IDLE      = 3'd2,
        RUN       = 3'd3,
        RELEASE   = 3'd4,
        DONE      = 3'd5
    } div_state_t;

    function automatic logic is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // INT_MIN maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? negate(v) : v;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response handshake bundle between issue logic and the divide sequencer.
interface div_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/div_result_fixup.sv
// Picks quotient or remainder, restores the sign, and overrides with the
// RISC-V divide-by-zero and signed-overflow results.
module div_result_fixup
    import mdu_pkg::*;
(
    input  div_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    input  logic        neg_q,
    input  logic        neg_r,
    output logic        special,
    output logic [31:0] result
);

    logic        div_zero_s;
    logic        overflow_s;
    logic [31:0] raw_s;
    logic        neg_s;

    // Special-case detection and final result selection.
    always_comb begin
        div_zero_s = (b == 32'd0);
        overflow_s = is_signed(op) && (a == INT_MIN) && (b == ALL_ONES);
        special    = div_zero_s || overflow_s;
        raw_s      = quotient;
        neg_s      = neg_q;
        result     = quotient;
        if (is_rem(op)) begin
            raw_s = remainder;
            neg_s = neg_r;
        end else begin
            raw_s = quotient;
            neg_s = neg_q;
        end
        if (div_zero_s) begin
            result = is_rem(op) ? a : ALL_ONES;
        end else if (overflow_s) begin
            result = is_rem(op) ? 32'd0 : INT_MIN;
        end else if (neg_s) begin
            result = negate(raw_s);
        end else begin
            result = raw_s;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Control stage driving the unsigned iterative divider core for DIV/DIVU/REM/REMU,
// including draining the unreset core after every reset.
module div_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    div_sequencer_if.slave  bus,
    output logic [XLEN-1:0] core_a,
    output logic [XLEN-1:0] core_b,
    output logic            core_enable,
    input  logic [XLEN-1:0] core_quotient,
    input  logic [XLEN-1:0] core_remainder,
    input  logic            core_valid
);

    localparam logic [XLEN-1:0] CORE_B_SAFE = {{(XLEN-1){1'b0}}, 1'b1};

    div_state_t       state_r, state_s;
    div_op_t          op_r, op_s;
    logic [TAG_W-1:0] tag_r, tag_s;
    logic             neg_q_r, neg_q_s, neg_r_r, neg_r_s;
    logic [XLEN-1:0]  core_a_r, core_a_s, core_b_r, core_b_s;
    logic             core_enable_r, core_enable_s;
    logic             req_ready_r, req_ready_s;
    logic             resp_valid_r, resp_valid_s;
    logic [XLEN-1:0]  resp_data_r, resp_data_s;
    logic [TAG_W-1:0] resp_tag_r, resp_tag_s;

    div_op_t          req_op_s;
    logic             req_neg_q_s, req_neg_r_s;
    div_op_t          fix_op_s;
    logic [XLEN-1:0]  fix_a_s, fix_b_s;
    logic             fix_neg_q_s, fix_neg_r_s;
    logic             fix_special_s;
    logic [XLEN-1:0]  fix_result_s;

    assign req_op_s    = div_op_t'(bus.req_op);
    assign req_neg_q_s = is_signed(req_op_s) & (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
    assign req_neg_r_s = is_signed(req_op_s) & bus.req_a[XLEN-1];

    // In IDLE the fixup judges the incoming request; otherwise the latched operation.
    always_comb begin
        fix_op_s    = op_r;
        fix_a_s     = core_a_r;
        fix_b_s     = core_b_r;
        fix_neg_q_s = neg_q_r;
        fix_neg_r_s = neg_r_r;
        if (state_r == IDLE) begin
            fix_op_s    = req_op_s;
            fix_a_s     = bus.req_a;
            fix_b_s     = bus.req_b;
            fix_neg_q_s = req_neg_q_s;
            fix_neg_r_s = req_neg_r_s;
        end else begin
            fix_op_s    = op_r;
            fix_a_s     = core_a_r;
            fix_b_s     = core_b_r;
            fix_neg_q_s = neg_q_r;
            fix_neg_r_s = neg_r_r;
        end
    end

    div_result_fixup u_fixup (
        .op        (fix_op_s),
        .a         (fix_a_s),
        .b         (fix_b_s),
        .quotient  (core_quotient),
        .remainder (core_remainder),
        .neg_q     (fix_neg_q_s),
        .neg_r     (fix_neg_r_s),
        .special   (fix_special_s),
        .result    (fix_result_s)
    );

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_s       = state_r;
        op_s          = op_r;
        tag_s         = tag_r;
        neg_q_s       = neg_q_r;
        neg_r_s       = neg_r_r;
        core_a_s      = core_a_r;
        core_b_s      = core_b_r;
        core_enable_s = 1'b0;
        req_ready_s   = 1'b0;
        resp_valid_s  = 1'b0;
        resp_data_s   = resp_data_r;
        resp_tag_s    = resp_tag_r;
        case (state_r)
            FLUSH: begin
                core_a_s = {XLEN{1'b0}};
                core_b_s = CORE_B_SAFE;
                if (core_enable_r && core_valid) begin
                    state_s = RELEASE_F;
                end else if (core_enable_r) begin
                    core_enable_s = 1'b1;
                end else if (!core_valid) begin
                    core_enable_s = 1'b1;
                end else begin
                    core_enable_s = 1'b0;
                end
            end
            RELEASE_F: begin
                if (!core_valid) begin
                    state_s     = IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    state_s = RELEASE_F;
                end
            end
            IDLE: begin
                req_ready_s = 1'b1;
                if (bus.req_valid && req_ready_r) begin
                    req_ready_s = 1'b0;
                    op_s        = req_op_s;
                    tag_s       = bus.req_tag;
                    neg_q_s     = req_neg_q_s;
                    neg_r_s     = req_neg_r_s;
                    if (fix_special_s) begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                        resp_data_s  = fix_result_s;
                        resp_tag_s   = bus.req_tag;
                    end else begin
                        state_s       = RUN;
                        core_enable_s = 1'b1;
                        core_a_s      = is_signed(req_op_s) ? magnitude(bus.req_a) : bus.req_a;
                        core_b_s      = is_signed(req_op_s) ? magnitude(bus.req_b) : bus.req_b;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (core_valid) begin
                    state_s     = RELEASE;
                    resp_data_s = fix_result_s;
                    resp_tag_s  = tag_r;
                end else begin
                    core_enable_s = 1'b1;
                end
            end
            RELEASE: begin
                if (!core_valid) begin
                    state_s      = DONE;
                    resp_valid_s = 1'b1;
                end else begin
                    state_s = RELEASE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_s     = IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    resp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = FLUSH;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= FLUSH;
            op_r          <= DIVU;
            tag_r         <= {TAG_W{1'b0}};
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            core_a_r      <= {XLEN{1'b0}};
            core_b_r      <= CORE_B_SAFE;
            core_enable_r <= 1'b0;
            req_ready_r   <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= {XLEN{1'b0}};
            resp_tag_r    <= {TAG_W{1'b0}};
        end else begin
            state_r       <= state_s;
            op_r          <= op_s;
            tag_r         <= tag_s;
            neg_q_r       <= neg_q_s;
            neg_r_r       <= neg_r_s;
            core_a_r      <= core_a_s;
            core_b_r      <= core_b_s;
            core_enable_r <= core_enable_s;
            req_ready_r   <= req_ready_s;
            resp_valid_r  <= resp_valid_s;
            resp_data_r   <= resp_data_s;
            resp_tag_r    <= resp_tag_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_tag   = resp_tag_r;
    assign core_a         = core_a_r;
    assign core_b         = core_b_r;
    assign core_enable    = core_enable_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a cycle-level divider core model and a
// scoreboard computing RISC-V divide results with plain signed/unsigned arithmetic.
module tb_div_sequencer;
    import mdu_pkg::*;

    logic clock;
    logic reset;
    logic [31:0] core_a, core_b, core_q, core_r;
    logic        core_enable;
    logic        core_valid = 1'b1;
    int          core_cnt   = 0;
    int          core_stale = 6;
    int          en_count   = 0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  tag;
        bit          special;
        int          hold;
    } vec_t;

    div_sequencer_if #(.XLEN(32), .TAG_W(5)) bus ();

    div_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus.slave),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_enable    (core_enable),
        .core_quotient  (core_q),
        .core_remainder (core_r),
        .core_valid     (core_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Divider core: no reset, starts with a stale valid, result after 32 enabled edges.
    always @(posedge clock) begin
        if (core_stale > 0) begin
            core_stale <= core_stale - 1;
        end else if (core_enable) begin
            if (!core_valid) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 31) begin
                    core_valid <= 1'b1;
                    core_q     <= (core_b != 32'd0) ? core_a / core_b : 32'hFFFF_FFFF;
                    core_r     <= (core_b != 32'd0) ? core_a % core_b : core_a;
                end
            end
        end else begin
            core_valid <= 1'b0;
            core_cnt   <= 0;
        end
    end

    always @(posedge clock) begin
        if (core_enable) en_count <= en_count + 1;
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic wait_flush();
        int start;
        bit ok;
        start = en_count;
        ok    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("flush_ready_rise", {31'd0, ok}, 32'd1);
        check("flush_enabled_edges", {31'd0, (en_count - start) >= 32}, 32'd1);
        check("flush_core_valid_low", {31'd0, core_valid}, 32'd0);
    endtask

    task automatic run_req(input vec_t v);
        int  n;
        int  lat;
        int  en_start;
        bit  ok;
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.req_tag   = v.tag;
        ok = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_accept", {31'd0, ok}, 32'd1);
        @(posedge clock);
        en_start = en_count;
        #1 bus.req_valid = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (n = 1; n <= 200; n++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                ok  = 1'b1;
                lat = n;
                break;
            end
        end
        check("resp_arrives", {31'd0, ok}, 32'd1);
        if (v.special) begin
            check("special_latency", lat, 32'd1);
            check("special_no_core", en_count - en_start, 32'd0);
        end else begin
            check("normal_latency_min", {31'd0, lat >= 33}, 32'd1);
        end
        check("resp_data_lit", bus.resp_data, v.exp);
        check("resp_tag_lit", {27'd0, bus.resp_tag}, {27'd0, v.tag});
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_data", bus.resp_data, v.exp);
            check("hold_tag", {27'd0, bus.resp_tag}, {27'd0, v.tag});
            check("hold_ready_low", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clock); #1 bus.resp_ready = 1'b1;
        @(posedge clock); #1 bus.resp_ready = 1'b0;
        @(negedge clock);
        check("resp_valid_drops", {31'd0, bus.resp_valid}, 32'd0);
    endtask

    vec_t vecs[12];
    vec_t v_mid;
    vec_t v_after;

    initial begin
        exp_t exp_q[$];
        bit   ok;

        vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 5'd1,  1'b0, 0};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 5'd2,  1'b0, 0};
        vecs[2]  = '{2'b01, 32'd7,         32'd2,          32'd3,         5'd3,  1'b0, 10};
        vecs[3]  = '{2'b00, 32'd5,         32'd0,          32'hFFFF_FFFF, 5'd4,  1'b1, 0};
        vecs[4]  = '{2'b11, 32'd5,         32'd0,          32'd5,         5'd5,  1'b1, 0};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd6,  1'b1, 0};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd7,  1'b1, 10};
        vecs[7]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd8,  1'b0, 0};
        vecs[8]  = '{2'b00, 32'd0,         32'hFFFF_FFFB, 32'd0,         5'd10, 1'b0, 0};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd11, 1'b0, 0};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'd2,          32'hC000_0000, 5'd13, 1'b0, 0};
        vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd14, 1'b0, 0};
        v_mid    = '{2'b01, 32'd100,       32'd7,          32'd14,        5'd9,  1'b0, 0};
        v_after  = '{2'b01, 32'd100,       32'd7,          32'd14,        5'd12, 1'b0, 0};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.req_tag    = 5'd0;
        bus.resp_ready = 1'b0;

        // Scoreboard: expected results pushed at request handshake, compared while resp_valid.
        fork
            forever begin
                @(negedge clock);
                if (reset) begin
                    exp_q.delete();
                end else begin
                    if (bus.resp_valid) begin
                        if (exp_q.size() == 0) begin
                            check("sb_unexpected_resp", 32'd1, 32'd0);
                        end else begin
                            check("sb_data", bus.resp_data, exp_q[0].data);
                            check("sb_tag", {27'd0, bus.resp_tag}, {27'd0, exp_q[0].tag});
                            if (bus.resp_ready) void'(exp_q.pop_front());
                        end
                        check("sb_ready_in_done", {31'd0, bus.req_ready}, 32'd0);
                    end
                    if (core_enable) check("sb_ready_in_run", {31'd0, bus.req_ready}, 32'd0);
                    if (bus.req_valid && bus.req_ready)
                        exp_q.push_back('{ref_result(bus.req_op, bus.req_a, bus.req_b), bus.req_tag});
                end
            end
        join_none

        check("model_div_neg",  ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem_neg",  ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_div_ovf",  ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_remu_dz",  ref_result(2'b11, 32'd5, 32'd0), 32'd5);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready",   {31'd0, bus.req_ready},   32'd0);
        check("rst_resp_valid",  {31'd0, bus.resp_valid},  32'd0);
        check("rst_resp_data",   bus.resp_data,            32'd0);
        check("rst_resp_tag",    {27'd0, bus.resp_tag},    32'd0);
        check("rst_core_enable", {31'd0, core_enable},     32'd0);
        check("rst_core_a",      core_a,                   32'd0);
        check("rst_core_b",      core_b,                   32'd1);
        @(posedge clock); #1 reset = 1'b0;
        wait_flush();

        for (int i = 0; i < 12; i++) run_req(vecs[i]);

        // Reset in the middle of a run discards the request and re-drains the core.
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = v_mid.op;
        bus.req_a     = v_mid.a;
        bus.req_b     = v_mid.b;
        bus.req_tag   = v_mid.tag;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_req_accept", {31'd0, ok}, 32'd1);
        @(posedge clock); #1 bus.req_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("mid_core_running", {31'd0, core_enable}, 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("mid_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mid_rst_core_enable", {31'd0, core_enable}, 32'd0);
        check("mid_rst_core_b", core_b, 32'd1);
        @(posedge clock); #1 reset = 1'b0;
        wait_flush();
        run_req(v_after);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control stage between the execute-stage M-extension issue logic and the 32-bit unsigned iterative divider core.
- Accepts RISC-V DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Converts signed operands to magnitudes and drives the core through its enable/data_valid protocol.
- Applies sign correction and the RISC-V special cases, then holds the result until the consumer accepts it.

Parameters:
- XLEN, 32, operand/result width; the core interface is fixed at 32, so only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  XLEN  dividend
- req_b  in  XLEN  divisor
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  final quotient or remainder
- resp_tag  out  TAG_W  tag of the accepted request
- core_a  out  XLEN  unsigned dividend to core
- core_b  out  XLEN  unsigned divisor to core
- core_enable  out  1  core run/hold enable
- core_quotient  in  XLEN  core quotient
- core_remainder  in  XLEN  core remainder
- core_valid  in  1  core result ready

Behaviour:
Reset values:
- On reset assertion: state=FLUSH, req_ready=0, resp_valid=0, resp_data=0, resp_tag=0, core_enable=0, core_a=0, core_b=1.

States:
- FLUSH. The core has no reset, so its state is unknown.
  - Wait while core_valid=1.
  - Then assert core_enable with core_a=0, core_b=1 until core_valid=1.
  - Then go to RELEASE_F.
- RELEASE_F. core_enable=0; when core_valid=0, go to IDLE.
- IDLE.
  - req_ready=1. A handshake occurs when req_valid&req_ready.
  - On handshake, latch op, tag, operands, neg_q=signed_op&(a[31]^b[31]) and neg_r=signed_op&a[31].
  - Special cases go straight to DONE with the result registered:
    - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
    - Signed op with a==0x80000000 and b==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Otherwise go to RUN with core_a=|a|, core_b=|b|. Magnitudes are taken only for signed ops; |0x80000000| = 0x80000000 unsigned.
- RUN.
  - core_enable=1; core_a/core_b are held stable.
  - When core_valid=1, capture quotient or remainder per op, apply negation (two's complement) per neg_q/neg_r, and go to RELEASE.
- RELEASE. core_enable=0; when core_valid=0, go to DONE.
- DONE.
  - resp_valid=1 with resp_data/resp_tag stable.
  - On resp_valid&resp_ready, go to IDLE. resp_valid drops the next cycle.
  - Back-to-back issue is not allowed: req_ready is 1 only in IDLE.

Timing and other rules:
- Latency: special case = 1 cycle from handshake to resp_valid. Normal = handshake, then RUN (core_valid rises after 32 enabled edges), then RELEASE (1–2 cycles), then DONE.
- req_ready=0 in every state except IDLE.
- Result width: all arithmetic is mod 2^32. A zero result is never negated to anything other than 0.
- Reset mid-operation: all state is discarded with no response, and the block re-enters FLUSH, so the core is drained before the next request.
- Simultaneous resp_ready and req_valid in DONE: only the response handshake takes effect; the request is accepted next cycle in IDLE.

Decomposition:
- Shared package mdu_pkg:
  - div_op_t enum (DIV, DIVU, REM, REMU)
  - div_state_t enum (FLUSH, RELEASE_F, IDLE, RUN, RELEASE, DONE)
  - constants INT_MIN=32'h8000_0000 and ALL_ONES=32'hFFFF_FFFF
  - helper is_signed(op)
- One sub-module, div_result_fixup: combinational; selects quotient/remainder, applies sign correction and special-case muxing.

Test Plan:
- After reset, hold req_valid low → req_ready stays 0 through the FLUSH dummy run; it rises once core_valid returns 0.
- DIV a=-7 (0xFFFFFFF9), b=2 → resp_data=0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU a=7, b=2 → 3.
- DIV a=5, b=0 → resp_data=0xFFFFFFFF one cycle after the handshake; REMU a=5, b=0 → 5; core_enable never asserted.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM of the same → 0; both in 1 cycle.
- Hold resp_ready=0 for 10 cycles in DONE → resp_data/resp_tag stable and req_ready=0; on release, the next request is accepted in IDLE.
- Assert reset during RUN of DIVU 100/7 → no response; FLUSH completes. A subsequent DIVU 100/7 → 14 with the correct tag.
